// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared state encoding and default sizing for int_ctrl
//
// Purpose: FSM state encoding and default parameter values shared by the
//          interrupt controller and its per-source synchroniser.
// Contents:
//   int_state_e          - INT_IDLE=0, INT_REQ=1, INT_SERVICE=2 (3 is unused)
//   N_SRC_DEFAULT        - number of interrupt sources (matches CPU grant width)
//   SYNC_STAGES_DEFAULT  - synchroniser depth per request line
package int_ctrl_pkg;

  localparam int N_SRC_DEFAULT       = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    INT_IDLE    = 2'd0,
    INT_REQ     = 2'd1,
    INT_SERVICE = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_ctrl_irq_sync.sv
// rtl/int_ctrl_irq_sync.sv - request line synchroniser with rising-edge detect
//
// Purpose: brings one asynchronous request line into the clk domain and
//          produces a one-cycle pulse for each rising edge.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   irq    in   raw asynchronous request line
//   evt    out  one-cycle event pulse (synchronised level & ~history)
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller: pending latch, priority select, Ireq/Iack FSM
//
// Purpose: latches edge events from N_SRC asynchronous lines as pending,
//          masks with int_en, picks the lowest-index eligible source and runs
//          the Ireq/Iack/eret handshake with the CPU.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   irq_in   in   raw request lines, rising edge = event
//   int_en   in   per-source enable from the CPU
//   Iack     in   CPU acknowledge pulse (honoured only in REQ)
//   eret     in   CPU return-from-interrupt pulse (honoured only in SERVICE)
//   ovf_clr  in   write-1-to-clear for ovf
//   Ireq     out  registered interrupt request
//   gntInt   out  registered one-hot grant, zero while Ireq is low
//   pending  out  latched pending events
//   ovf      out  sticky overflow: edge arrived while already pending
//   state_o  out  FSM state (IDLE=0, REQ=1, SERVICE=2)
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] int_en,
  input  logic             Iack,
  input  logic             eret,
  input  logic [N_SRC-1:0] ovf_clr,
  output logic             Ireq,
  output logic [N_SRC-1:0] gntInt,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] ovf,
  output logic [1:0]       state_o
);

  logic [N_SRC-1:0] ev;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] ovf_q;
  logic [N_SRC-1:0] gnt_q;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] winner;
  logic [N_SRC-1:0] ack_clr;
  int_state_e       state_q;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq_in[g]),
      .evt   (ev[g])
    );
  end

  assign eligible = pending_q & int_en;

  // Lowest index wins: scan from the top so the last hit is the lowest bit.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end

  assign ack_clr = (state_q == INT_REQ && Iack) ? gnt_q : '0;

  // A fresh event beats the acknowledge clear; it re-arms the source rather
  // than counting as an overflow of the request being acknowledged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_clr) | ev;
      ovf_q     <= (ovf_q & ~ovf_clr) | (ev & pending_q & ~ack_clr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INT_IDLE;
      gnt_q   <= '0;
      Ireq    <= 1'b0;
      gntInt  <= '0;
    end else begin
      case (state_q)
        INT_REQ: begin
          if (Iack) begin
            state_q <= INT_SERVICE;
            Ireq    <= 1'b0;
            gntInt  <= '0;
          end else if ((gnt_q & int_en) == '0) begin
            state_q <= INT_IDLE;
            Ireq    <= 1'b0;
            gntInt  <= '0;
          end
        end
        INT_SERVICE: begin
          if (eret) begin
            state_q <= INT_IDLE;
          end
        end
        // INT_IDLE and the unused encoding both behave as idle.
        default: begin
          Ireq   <= 1'b0;
          gntInt <= '0;
          if (eligible != '0) begin
            state_q <= INT_REQ;
            gnt_q   <= winner;
            Ireq    <= 1'b1;
            gntInt  <= winner;
          end else begin
            state_q <= INT_IDLE;
          end
        end
      endcase
    end
  end

  assign pending = pending_q;
  assign ovf     = ovf_q;
  assign state_o = state_q;

endmodule
